// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: zero-fills the register file after reset, then forwards pipeline
// traffic and slots debug-host reads/writes between instructions while stalling the pipe.
module regfile_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_wrAddr,
  input  logic [DATA_WIDTH-1:0] cpu_wrData,
  input  logic [ADDR_WIDTH-1:0] cpu_rdAddrA,
  input  logic [ADDR_WIDTH-1:0] cpu_rdAddrB,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  init_done,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_wrAddr,
  output logic [DATA_WIDTH-1:0] rf_wrData,
  output logic [ADDR_WIDTH-1:0] rf_rdAddrA,
  output logic [ADDR_WIDTH-1:0] rf_rdAddrB,
  input  logic [DATA_WIDTH-1:0] rf_rdDataA
);
  typedef enum logic [2:0] {CLEAR, CLR_FLUSH, IDLE, DWR, DRD, DCAP, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_idx;
  assign cpu_stall  = state != IDLE;
  assign dbg_ack    = state == DONE;
  assign rf_rdAddrB = cpu_rdAddrB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= CLEAR;
      clr_idx   <= ADDR_WIDTH'(1);
      init_done <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if (state == CLR_FLUSH) init_done <= 1'b1;
      if (state == DCAP) dbg_rdata <= (dbg_addr == '0) ? '0 : rf_rdDataA;
    end
  always_comb begin
    state_nx   = state;
    rf_write   = 1'b0;
    rf_wrAddr  = cpu_wrAddr;
    rf_wrData  = cpu_wrData;
    rf_rdAddrA = cpu_rdAddrA;
    case (state)
      CLEAR: begin
        // state sits in CLEAR throughout reset, so the write is gated by rst_n
        rf_write  = rst_n;
        rf_wrAddr = clr_idx;
        rf_wrData = '0;
        state_nx  = (&clr_idx) ? CLR_FLUSH : CLEAR;
      end
      CLR_FLUSH: state_nx = IDLE;
      IDLE: begin
        rf_write = cpu_write;
        state_nx = dbg_req ? (dbg_we ? DWR : DRD) : IDLE;
      end
      DWR: begin
        rf_write  = dbg_addr != '0;
        rf_wrAddr = dbg_addr;
        rf_wrData = dbg_wdata;
        state_nx  = DONE;
      end
      DRD: begin
        rf_rdAddrA = dbg_addr;
        state_nx   = DCAP;
      end
      DCAP: state_nx = DONE;
      DONE: state_nx = dbg_req ? DONE : IDLE;
      default: state_nx = CLEAR;
    endcase
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed stimulus against a cycle-phase model of the controller
// plus a bench-side register file with registered read port A.
module tb_regfile_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, cpu_write, cpu_stall, dbg_req, dbg_we, dbg_ack, init_done, rf_write;
  logic [4:0] cpu_wrAddr, cpu_rdAddrA, cpu_rdAddrB, dbg_addr, rf_wrAddr, rf_rdAddrA, rf_rdAddrB;
  logic [31:0] cpu_wrData, dbg_wdata, dbg_rdata, rf_wrData, rd_a;
  int total = 0, bad = 0;

  regfile_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_write(cpu_write), .cpu_wrAddr(cpu_wrAddr),
    .cpu_wrData(cpu_wrData), .cpu_rdAddrA(cpu_rdAddrA), .cpu_rdAddrB(cpu_rdAddrB),
    .cpu_stall(cpu_stall), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .init_done(init_done),
    .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
    .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB), .rf_rdDataA(rd_a)
  );

  // register file with power-up garbage so the clear sequence is observable
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 + i;
  always @(posedge clk) begin
    if (rf_write) mem[rf_wrAddr] <= rf_wrData;
    rd_a <= mem[rf_rdAddrA];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: k = cycles since reset release (clear phase while < 32); a debug op is
  // tracked by n = cycles since it was accepted in an unstalled cycle
  int k = 0, n = 0;
  bit dbg = 0, op_we = 0;
  logic [4:0] op_addr = '0;
  logic [31:0] op_wdata = '0, exp_rdata = '0;
  logic [31:0] shadow [32];
  initial for (int i = 0; i < 32; i++) shadow[i] = 32'hBAD0_0000 + i;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; dbg = 0; n = 0; exp_rdata = '0;
    end else if (k < 32) begin
      if (k < 31) shadow[k + 1] = '0;
      k++;
    end else if (dbg) begin
      if (n >= (op_we ? 2 : 3) && !dbg_req) dbg = 0;
      else begin
        if (op_we && n == 1 && op_addr != 0) shadow[op_addr] = op_wdata;
        if (!op_we && n == 2) exp_rdata = (op_addr == 0) ? '0 : shadow[op_addr];
        n++;
      end
    end else begin
      if (cpu_write) shadow[cpu_wrAddr] = cpu_wrData;
      if (dbg_req) begin
        dbg = 1; n = 1; op_we = dbg_we; op_addr = dbg_addr; op_wdata = dbg_wdata;
      end
    end
  end

  bit clr, wop, e_wr;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall", cpu_stall, 1); chk("rst_ack", dbg_ack, 0);
      chk("rst_rdata", dbg_rdata, 0); chk("rst_init", init_done, 0);
      chk("rst_wr", rf_write, 0);
    end else begin
      clr  = k < 32;
      wop  = dbg && op_we && n == 1;
      e_wr = clr ? (k < 31) : dbg ? (wop && op_addr != 0) : cpu_write;
      chk("m_stall", cpu_stall, clr || dbg);
      chk("m_init", init_done, !clr);
      chk("m_ack", dbg_ack, dbg && n >= (op_we ? 2 : 3));
      chk("m_rdata", dbg_rdata, exp_rdata);
      chk("m_wr", rf_write, e_wr);
      if (e_wr) begin
        chk("m_wraddr", rf_wrAddr, clr ? 5'(k + 1) : wop ? op_addr : cpu_wrAddr);
        chk("m_wrdata", rf_wrData, clr ? 32'h0 : wop ? op_wdata : cpu_wrData);
      end
      chk("m_rdA", rf_rdAddrA, (dbg && !op_we && n == 1) ? op_addr : cpu_rdAddrA);
      chk("m_rdB", rf_rdAddrB, cpu_rdAddrB);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_check();
    int cnt = 0;
    logic [31:0] acc = '0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (!cpu_stall) break;
      cnt++;
      cyc();
    end
    chk("clear_len", cnt, 32);
    chk("clear_init", init_done, 1);
    for (int i = 1; i < 32; i++) acc |= mem[i];
    chk("clear_mem", acc, 0);
    cyc();
  endtask

  task automatic dbg_op(input bit we, input logic [4:0] a, input logic [31:0] d, input int hold,
                        output int lat, output int acks, output logic [31:0] rd,
                        output bit wr_seen, output bit acc_wr);
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1;
    lat = 0; acks = 0; wr_seen = 0; rd = 'x;
    #2 acc_wr = rf_write;
    chk("acc_stall", cpu_stall, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(); #2;
      wr_seen |= rf_write;
      if (dbg_ack) begin lat = i; break; end
    end
    rd = dbg_rdata;
    acks = dbg_ack ? 1 : 0;
    for (int i = 0; i < hold; i++) begin
      cyc(); #2;
      acks += dbg_ack ? 1 : 0;
      wr_seen |= rf_write;
    end
    dbg_req = 0;
    cyc();
  endtask

  initial begin
    int lat, acks;
    logic [31:0] rd;
    bit wr_seen, acc_wr;
    rst_n = 0; cpu_write = 0; cpu_wrAddr = 0; cpu_wrData = 0; cpu_rdAddrA = 0; cpu_rdAddrB = 9;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    #2;
    chk("r0_stall", cpu_stall, 1); chk("r0_ack", dbg_ack, 0); chk("r0_wr", rf_write, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clear_check();
    cpu_write = 1; cpu_wrAddr = 5; cpu_wrData = 32'hDEADBEEF; cpu_rdAddrB = 5;
    #2 chk("cw_wr", rf_write, 1); chk("cw_addr", rf_wrAddr, 5);
    cyc();
    cpu_write = 0; cpu_rdAddrA = 5;
    cyc(); #2 chk("cw_read", rd_a, 32'hDEADBEEF);
    cyc();
    cpu_rdAddrA = 7;
    dbg_op(1, 7, 32'h12345678, 0, lat, acks, rd, wr_seen, acc_wr);
    chk("dw_lat", lat, 2); chk("dw_wr", wr_seen, 1); chk("dw_acc", acc_wr, 0);
    #2 chk("dw_unstall", cpu_stall, 0); chk("dw_fresh", rd_a, 32'h12345678);
    cyc();
    dbg_op(0, 7, 0, 0, lat, acks, rd, wr_seen, acc_wr);
    chk("dr_lat", lat, 3); chk("dr_data", rd, 32'h12345678); chk("dr_wr", wr_seen, 0);
    dbg_op(0, 0, 0, 0, lat, acks, rd, wr_seen, acc_wr);
    chk("dr0_data", rd, 0);
    dbg_op(1, 0, 32'hFFFFFFFF, 0, lat, acks, rd, wr_seen, acc_wr);
    chk("dw0_lat", lat, 2); chk("dw0_wr", wr_seen, 0);
    cpu_write = 1; cpu_wrAddr = 3; cpu_wrData = 32'hA5A5A5A5;
    dbg_op(0, 3, 0, 3, lat, acks, rd, wr_seen, acc_wr);
    chk("mix_acc", acc_wr, 1); chk("mix_held", wr_seen, 0); chk("mix_acks", acks, 4);
    chk("mix_data", rd, 32'hA5A5A5A5);
    #2 chk("mix_refwd", rf_write, 1);
    cpu_write = 0;
    cyc();
    dbg_req = 1; dbg_we = 0; dbg_addr = 7;
    cyc(); cyc();
    rst_n = 0;
    #1;
    chk("ra_ack", dbg_ack, 0); chk("ra_rdata", dbg_rdata, 0); chk("ra_stall", cpu_stall, 1);
    dbg_req = 0;
    cyc();
    rst_n = 1;
    clear_check();
    dbg_op(0, 3, 0, 0, lat, acks, rd, wr_seen, acc_wr);
    chk("post_clr", rd, 0);
    cpu_rdAddrA = 5;
    cyc(); #2 chk("post_clr_pipe", rd_a, 0);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
